// File: rtl/mem_stream_if.sv
// mem_stream_if: stream input, burst control/status and read port of the memory stream writer
interface mem_stream_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
);
  logic              start;
  logic              abort;
  logic              in_valid;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   remaining;
  logic [WIDTH-1:0]  in_data;
  logic [WIDTH-1:0]  rd_data;
  modport master (
    output start, base_addr, count, abort, in_valid, in_data, rd_addr,
    input  in_ready, busy, done, wr_ptr, remaining, rd_data
  );
  modport slave (
    input  start, base_addr, count, abort, in_valid, in_data, rd_addr,
    output in_ready, busy, done, wr_ptr, remaining, rd_data
  );
endinterface

// File: rtl/mem_stream_writer.sv
// mem_stream_writer: fills a register-file memory from a valid/ready stream, wrapping at DEPTH
module mem_stream_writer #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic         clk,
  input logic         rst_n,
  mem_stream_if.slave s
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   remaining;
  logic [WIDTH-1:0]  mem [DEPTH];
  assign s.in_ready  = state == FILL;
  assign s.busy      = state != IDLE;
  assign s.done      = state == DONE;
  assign s.wr_ptr    = wr_ptr;
  assign s.remaining = remaining;
  assign s.rd_data   = mem[s.rd_addr];
  // wr_ptr is exactly ADDR_W bits wide, so the increment wraps DEPTH-1 -> 0 by itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      remaining <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: if (s.start) begin
          wr_ptr    <= s.base_addr;
          remaining <= s.count;
          state     <= (s.count == '0) ? DONE : FILL;
        end
        FILL: if (s.abort) begin
          state <= IDLE;
        end else if (s.in_valid) begin
          mem[wr_ptr] <= s.in_data;
          wr_ptr      <= wr_ptr + 1'b1;
          remaining   <= remaining - 1'b1;
          if (remaining == (ADDR_W+1)'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stream_writer.sv
// tb_mem_stream_writer: directed bursts with hand-computed memory images and status values
module tb_mem_stream_writer;
  logic clk = 0;
  logic rst_n = 0;
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [15:0] model [16];
  logic [15:0] vec [16];
  mem_stream_if #(.WIDTH(16), .ADDR_W(4)) bus ();
  mem_stream_writer #(.WIDTH(16), .DEPTH(16), .ADDR_W(4)) dut (.clk(clk), .rst_n(rst_n), .s(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.done) done_cnt++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_mem(input string tag);
    for (int i = 0; i < 16; i++) begin
      bus.rd_addr = 4'(i);
      #1;
      chk($sformatf("%s_mem%0d", tag, i), 32'(bus.rd_data), 32'(model[i]));
    end
    @(negedge clk);
  endtask
  task automatic start_burst(input logic [3:0] base, input logic [4:0] cnt);
    bus.start = 1; bus.base_addr = base; bus.count = cnt;
    @(negedge clk);
    bus.start = 0;
  endtask
  task automatic send(input int n, input int gap, input string tag);
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g < gap; g++) begin
        bus.in_valid = 0;
        @(negedge clk);
        chk({tag, "_rdy_gap"}, 32'(bus.in_ready), 1);
      end
      bus.in_valid = 1; bus.in_data = vec[k];
      chk({tag, "_rdy"}, 32'(bus.in_ready), 1);
      @(negedge clk);
      bus.in_valid = 0;
    end
  endtask
  initial begin
    int d0;
    bus.start = 0; bus.abort = 0; bus.in_valid = 0; bus.in_data = '0;
    bus.base_addr = '0; bus.count = '0; bus.rd_addr = '0;
    for (int i = 0; i < 16; i++) model[i] = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.in_ready), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_ptr", 32'(bus.wr_ptr), 0);
    chk("rst_rem", 32'(bus.remaining), 0);
    check_mem("rst");
    rst_n = 1;
    @(negedge clk);
    // full-depth burst from address 0
    for (int i = 0; i < 16; i++) vec[i] = (i == 15) ? 16'hFFFF : 16'(i + 1);
    for (int i = 0; i < 16; i++) model[i] = vec[i];
    start_burst(4'd0, 5'd16);
    chk("full_busy", 32'(bus.busy), 1);
    chk("full_rem0", 32'(bus.remaining), 16);
    send(16, 0, "full");
    chk("full_done", 32'(bus.done), 1);
    chk("full_ready_done", 32'(bus.in_ready), 0);
    chk("full_ptr", 32'(bus.wr_ptr), 0);
    chk("full_rem", 32'(bus.remaining), 0);
    @(negedge clk);
    chk("full_done_off", 32'(bus.done), 0);
    chk("full_idle", 32'(bus.busy), 0);
    chk("full_done_cnt", 32'(done_cnt), 1);
    check_mem("full");
    // wrap from 14 to 1
    vec[0] = 16'h00A1; vec[1] = 16'h00A2; vec[2] = 16'h00A3; vec[3] = 16'h00A4;
    model[14] = 16'h00A1; model[15] = 16'h00A2; model[0] = 16'h00A3; model[1] = 16'h00A4;
    start_burst(4'd14, 5'd4);
    send(4, 0, "wrap");
    chk("wrap_done", 32'(bus.done), 1);
    chk("wrap_ptr", 32'(bus.wr_ptr), 2);
    @(negedge clk);
    check_mem("wrap");
    // stalled burst with 2-cycle gaps
    d0 = done_cnt;
    vec[0] = 16'h00C1; vec[1] = 16'h00C2; vec[2] = 16'h00C3;
    model[3] = 16'h00C1; model[4] = 16'h00C2; model[5] = 16'h00C3;
    start_burst(4'd3, 5'd3);
    send(3, 2, "gap");
    chk("gap_done", 32'(bus.done), 1);
    @(negedge clk);
    chk("gap_done_once", 32'(done_cnt - d0), 1);
    check_mem("gap");
    // abort on the 4th word, presented together with in_valid
    d0 = done_cnt;
    vec[0] = 16'h0051; vec[1] = 16'h0052; vec[2] = 16'h0053;
    model[0] = 16'h0051; model[1] = 16'h0052; model[2] = 16'h0053;
    start_burst(4'd0, 5'd8);
    send(3, 0, "abort");
    bus.in_valid = 1; bus.in_data = 16'h0054; bus.abort = 1;
    @(negedge clk);
    bus.in_valid = 0; bus.abort = 0;
    chk("abort_idle", 32'(bus.busy), 0);
    chk("abort_ready", 32'(bus.in_ready), 0);
    chk("abort_rem", 32'(bus.remaining), 5);
    chk("abort_ptr", 32'(bus.wr_ptr), 3);
    @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 0);
    check_mem("abort");
    // zero-length burst goes straight to DONE
    start_burst(4'd9, 5'd0);
    chk("zero_done", 32'(bus.done), 1);
    chk("zero_ptr", 32'(bus.wr_ptr), 9);
    chk("zero_rem", 32'(bus.remaining), 0);
    @(negedge clk);
    chk("zero_done_off", 32'(bus.done), 0);
    check_mem("zero");
    // asynchronous reset in the middle of a burst
    d0 = done_cnt;
    vec[0] = 16'h0077; vec[1] = 16'h0078;
    start_burst(4'd2, 5'd4);
    send(2, 0, "mid");
    #2 rst_n = 0;
    #1;
    chk("mid_busy", 32'(bus.busy), 0);
    chk("mid_ready", 32'(bus.in_ready), 0);
    chk("mid_ptr", 32'(bus.wr_ptr), 0);
    chk("mid_rem", 32'(bus.remaining), 0);
    for (int i = 0; i < 16; i++) model[i] = 16'h0;
    check_mem("mid");
    rst_n = 1;
    @(negedge clk);
    chk("mid_no_done", 32'(done_cnt - d0), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
